quad_decoder: RTL and testbench

Quadrature decoder and position counter: the receiving end of the up/down counting path. It takes the two raw phase signals of an incremental encoder (A, B), synchronises and filters them, decodes direction and step from the Gray-code sequence, and maintains a wrap-around position count `Q` in the same format the up/down counter produces. The input sample rate comes from a prescaler strobe generator running on the single system clock, so no derived clocks are used.

---
 rtl/quad_pkg.sv | 27 ++
 rtl/sample_strobe.sv | 27 ++
 rtl/quad_decoder.sv | 116 +++++++++++
 tb/tb_quad_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: phase states, direction
// values and the Gray-code neighbour function used by the decoder.
package quad_pkg;

  // Phase state {a,b}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Neighbouring phase state in the requested direction
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic up);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = up ? PH_10 : PH_01;
      PH_10:   nxt = up ? PH_11 : PH_00;
      PH_11:   nxt = up ? PH_01 : PH_10;
      default: nxt = up ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sample_strobe.sv
// Sample-rate enable generator: a one-cycle strobe every prescaler+1
// cycles. The >= compare lets prescaler shrink mid-count without waiting
// for the counter to wrap all the way around.
module sample_strobe #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] prescaler,
  output logic             strobe
);

  logic [DIV_W-1:0] count;

  assign strobe = (count >= prescaler);

  // Divider counter: restart on every strobe, otherwise count up
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (strobe)
      count <= '0;
    else
      count <= count + DIV_W'(1);
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder with position counter. Phases are synchronised,
// filtered on the sample strobe, and every accepted Gray-code edge moves
// the wrap-around count Q by one (x4 resolution).
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FILTER_LEN = 3,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic [DIV_W-1:0] prescaler,
  output logic [WIDTH-1:0] Q,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             err_sticky
);

  localparam logic [3:0] RUN_MAX = 4'(FILTER_LEN);

  logic       a_meta, a_sync, b_meta, b_sync;
  logic [1:0] sample;
  logic [1:0] cand;
  logic [3:0] run;
  logic [1:0] acc;
  logic       primed;
  logic       strobe;
  logic       accept;
  logic       is_up, is_dn;

  sample_strobe #(.DIV_W(DIV_W)) u_strobe (
    .clk       (clk),
    .reset     (reset),
    .prescaler (prescaler),
    .strobe    (strobe)
  );

  // Two-flop synchroniser for each asynchronous encoder phase
  always_ff @(posedge clk) begin
    if (reset) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      b_meta <= 1'b0;
      b_sync <= 1'b0;
    end else begin
      a_meta <= a;
      a_sync <= a_meta;
      b_meta <= b;
      b_sync <= b_meta;
    end
  end

  assign sample = {a_sync, b_sync};

  // Run-length filter: a new value must be seen on FILTER_LEN consecutive strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= PH_00;
      run  <= '0;
    end else if (strobe) begin
      if (sample == cand) begin
        if (run != RUN_MAX)
          run <= run + 4'd1;
      end else begin
        cand <= sample;
        run  <= 4'd1;
      end
    end
  end

  // Before priming any fully filtered value is taken; after that only a change counts
  always_comb begin
    accept = (run == RUN_MAX) && (!primed || (cand != acc));
    is_up  = (next_phase(acc, DIR_UP) == cand);
    is_dn  = (next_phase(acc, DIR_DN) == cand);
  end

  // Decode accepted transitions into count, direction and pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      Q          <= '0;
      dir        <= DIR_DN;
      step       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      primed     <= 1'b0;
      acc        <= PH_00;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        acc    <= cand;
        primed <= 1'b1;
        if (primed) begin
          if (is_up) begin
            Q    <= Q + WIDTH'(1);
            dir  <= DIR_UP;
            step <= 1'b1;
          end else if (is_dn) begin
            Q    <= Q - WIDTH'(1);
            dir  <= DIR_DN;
            step <= 1'b1;
          end else begin
            err        <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder at default parameters
// (WIDTH=4, FILTER_LEN=3, DIV_W=16).
module tb_quad_decoder;

  logic        clk;
  logic        reset;
  logic        a, b;
  logic [15:0] prescaler;
  logic [3:0]  Q;
  logic        dir, step, err, err_sticky;

  int total = 0;
  int bad   = 0;
  int step_cnt = 0;
  int err_cnt  = 0;

  quad_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .prescaler  (prescaler),
    .Q          (Q),
    .dir        (dir),
    .step       (step),
    .err        (err),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every cycle that step or err is high
  always @(negedge clk) begin
    if (step) step_cnt++;
    if (err)  err_cnt++;
  end

  // Compare helper macro-free: each test writes its comparisons inline
  task automatic drive_ab(input logic [1:0] v);
    @(posedge clk);
    #1 {a, b} = v;
  endtask

  task automatic test_reset;
    reset = 1'b1; prescaler = 16'd0; a = 1'b0; b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (Q !== 4'd0) begin bad++; $display("[TB] FAIL reset_Q got=%0d want=0", Q); end
    total++; if (dir !== 1'b0) begin bad++; $display("[TB] FAIL reset_dir got=%0b want=0", dir); end
    total++; if (step !== 1'b0) begin bad++; $display("[TB] FAIL reset_step got=%0b want=0", step); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0b want=0", err); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("[TB] FAIL reset_sticky got=%0b want=0", err_sticky); end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++; if (step_cnt !== 0) begin bad++; $display("[TB] FAIL prime_steps got=%0d want=0", step_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("[TB] FAIL prime_errs got=%0d want=0", err_cnt); end
    total++; if (Q !== 4'd0) begin bad++; $display("[TB] FAIL prime_Q got=%0d want=0", Q); end
  endtask

  task automatic test_up_cycles;
    logic [1:0] seq [4];
    int base;
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    base = step_cnt;
    // First edge: step must appear exactly 6 cycles after the input change
    drive_ab(seq[0]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (step !== 1'b0) begin bad++; $display("[TB] FAIL latency_early got=%0b want=0", step); end
    @(posedge clk);
    @(negedge clk);
    total++; if (step !== 1'b1) begin bad++; $display("[TB] FAIL latency_step got=%0b want=1", step); end
    total++; if (Q !== 4'd1) begin bad++; $display("[TB] FAIL latency_Q got=%0d want=1", Q); end
    for (int i = 1; i < 16; i++) begin
      drive_ab(seq[i % 4]);
      repeat (7) @(posedge clk);
      @(negedge clk);
      total++;
      if (Q !== 4'((i + 1) % 16) || dir !== 1'b1) begin
        bad++;
        $display("[TB] FAIL up_edge_%0d got Q=%0d dir=%0b want Q=%0d dir=1", i, Q, dir, (i + 1) % 16);
      end
    end
    total++; if (step_cnt - base !== 16) begin bad++; $display("[TB] FAIL up_steps got=%0d want=16", step_cnt - base); end
    // One down edge from 00 goes to 01 and wraps the count back to 15
    drive_ab(2'b01);
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (Q !== 4'd15) begin bad++; $display("[TB] FAIL down_Q got=%0d want=15", Q); end
    total++; if (dir !== 1'b0) begin bad++; $display("[TB] FAIL down_dir got=%0b want=0", dir); end
  endtask

  task automatic test_glitch;
    int base_s, base_e;
    base_s = step_cnt; base_e = err_cnt;
    drive_ab(2'b11);
    drive_ab(2'b01);
    repeat (10) @(posedge clk);
    drive_ab(2'b11);
    @(posedge clk);
    #1 {a, b} = 2'b01;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++; if (step_cnt - base_s !== 0) begin bad++; $display("[TB] FAIL glitch_steps got=%0d want=0", step_cnt - base_s); end
    total++; if (err_cnt - base_e !== 0) begin bad++; $display("[TB] FAIL glitch_errs got=%0d want=0", err_cnt - base_e); end
    total++; if (Q !== 4'd15) begin bad++; $display("[TB] FAIL glitch_Q got=%0d want=15", Q); end
  endtask

  task automatic test_illegal;
    int base_s, base_e;
    drive_ab(2'b00);
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (Q !== 4'd0 || dir !== 1'b1) begin bad++; $display("[TB] FAIL pre_illegal got Q=%0d dir=%0b want Q=0 dir=1", Q, dir); end
    base_s = step_cnt; base_e = err_cnt;
    drive_ab(2'b11);
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (err_cnt - base_e !== 1) begin bad++; $display("[TB] FAIL illegal_err_pulses got=%0d want=1", err_cnt - base_e); end
    total++; if (step_cnt - base_s !== 0) begin bad++; $display("[TB] FAIL illegal_steps got=%0d want=0", step_cnt - base_s); end
    total++; if (err_sticky !== 1'b1) begin bad++; $display("[TB] FAIL illegal_sticky got=%0b want=1", err_sticky); end
    total++; if (Q !== 4'd0 || dir !== 1'b1) begin bad++; $display("[TB] FAIL illegal_hold got Q=%0d dir=%0b want Q=0 dir=1", Q, dir); end
    // 11 -> 10 is a reverse edge measured from the newly accepted state
    base_s = step_cnt;
    drive_ab(2'b10);
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (Q !== 4'd15 || dir !== 1'b0) begin bad++; $display("[TB] FAIL after_illegal got Q=%0d dir=%0b want Q=15 dir=0", Q, dir); end
    total++; if (step_cnt - base_s !== 1) begin bad++; $display("[TB] FAIL after_illegal_steps got=%0d want=1", step_cnt - base_s); end
    total++; if (err_sticky !== 1'b1) begin bad++; $display("[TB] FAIL sticky_hold got=%0b want=1", err_sticky); end
  endtask

  task automatic test_prescaler;
    int base_s;
    int found;
    int period;
    base_s = step_cnt;
    // Divider sits at 0 here, so strobes fall in relative cycles 9, 19, 29, ...
    @(posedge clk);
    #1 prescaler = 16'd9;
    repeat (8) @(posedge clk);
    #1 {a, b} = 2'b11;
    repeat (25) @(posedge clk);
    #1 {a, b} = 2'b10;
    repeat (19) @(posedge clk);
    @(negedge clk);
    total++; if (step_cnt - base_s !== 0) begin bad++; $display("[TB] FAIL short_hold_steps got=%0d want=0", step_cnt - base_s); end
    total++; if (Q !== 4'd15) begin bad++; $display("[TB] FAIL short_hold_Q got=%0d want=15", Q); end
    // Long hold from cycle 53: strobes 59, 69, 79 fill the filter, output in cycle 81
    @(posedge clk);
    #1 {a, b} = 2'b11;
    repeat (27) @(posedge clk);
    @(negedge clk);
    total++; if (Q !== 4'd15) begin bad++; $display("[TB] FAIL long_hold_early got=%0d want=15", Q); end
    @(posedge clk);
    @(negedge clk);
    total++; if (Q !== 4'd0 || step !== 1'b1 || dir !== 1'b1) begin bad++; $display("[TB] FAIL long_hold got Q=%0d step=%0b dir=%0b want Q=0 step=1 dir=1", Q, step, dir); end
    // Shrinking prescaler mid-count must give a strobe within 3 cycles
    repeat (3) @(posedge clk);
    #1 prescaler = 16'd2;
    found = 0;
    for (int k = 1; k <= 3; k++) begin
      if (found == 0) begin
        @(negedge clk);
        if (dut.strobe) found = k;
        else @(posedge clk);
      end
    end
    total++; if (found == 0) begin bad++; $display("[TB] FAIL prescale_change got=none want=strobe_within_3"); end
    period = 0;
    for (int k = 1; k <= 12; k++) begin
      if (period == 0) begin
        @(posedge clk);
        @(negedge clk);
        if (dut.strobe) period = k;
      end
    end
    total++; if (period !== 3) begin bad++; $display("[TB] FAIL prescale_period got=%0d want=3", period); end
    @(posedge clk);
    #1 prescaler = 16'd0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midfilter;
    int base_s;
    base_s = step_cnt;
    drive_ab(2'b01);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (Q !== 4'd0 || dir !== 1'b0) begin bad++; $display("[TB] FAIL midreset_Q_dir got Q=%0d dir=%0b want Q=0 dir=0", Q, dir); end
    total++; if (step !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL midreset_pulses got step=%0b err=%0b want 0 0", step, err); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("[TB] FAIL midreset_sticky got=%0b want=0", err_sticky); end
    repeat (12) @(posedge clk);
    @(negedge clk);
    total++; if (step_cnt - base_s !== 0) begin bad++; $display("[TB] FAIL midreset_prime_steps got=%0d want=0", step_cnt - base_s); end
    total++; if (Q !== 4'd0) begin bad++; $display("[TB] FAIL midreset_prime_Q got=%0d want=0", Q); end
    // Primed on 01, so 01 -> 00 is an up edge
    drive_ab(2'b00);
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (Q !== 4'd1 || dir !== 1'b1) begin bad++; $display("[TB] FAIL post_prime got Q=%0d dir=%0b want Q=1 dir=1", Q, dir); end
    total++; if (step_cnt - base_s !== 1) begin bad++; $display("[TB] FAIL post_prime_steps got=%0d want=1", step_cnt - base_s); end
  endtask

  initial begin
    test_reset;
    test_up_cycles;
    test_glitch;
    test_illegal;
    test_prescaler;
    test_reset_midfilter;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
